pll_reset_sequencer: RTL and testbench

- Parametrised successor to the per-board PLL wrappers. It turns a raw PLL lock flag into N staged, glitch-free synchronous resets for the downstream clock-domain consumers (CPU, bus fabric, peripherals, ...).
- It filters the lock signal and releases the domain resets one at a time in index order.
- Loss of lock re-asserts every reset immediately.
- Sits directly after the PLL instance and is clocked by the PLL output.

---
 rtl/pll_reset_sequencer.sv | 177 +++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// Turns a raw PLL lock flag into N staged synchronous resets, released one at a time in index order.
// Define PLL_RESET_SEQUENCER_LOSS_COUNT_EN to build the lock-loss counter and sticky flag.
module pll_reset_sequencer #(
  parameter int unsigned N_DOMAINS     = 3,
  parameter int unsigned FILTER_CYCLES = 256,
  parameter int unsigned STAGE_GAP     = 16,
  parameter int unsigned W_LOSSCNT     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pll_locked,
  output logic [N_DOMAINS-1:0] rst_out,
  output logic                 all_released,
  input  logic                 loss_clear,
  output logic [W_LOSSCNT-1:0] loss_count,
  output logic                 loss_sticky
);

  if (N_DOMAINS < 1 || N_DOMAINS > 8) begin : g_bad_n_domains
    $error("N_DOMAINS must be in 1..8");
  end
  if (FILTER_CYCLES < 1) begin : g_bad_filter_cycles
    $error("FILTER_CYCLES must be >= 1");
  end
  if (STAGE_GAP < 1) begin : g_bad_stage_gap
    $error("STAGE_GAP must be >= 1");
  end
  if (W_LOSSCNT < 1) begin : g_bad_w_losscnt
    $error("W_LOSSCNT must be >= 1");
  end

  localparam int unsigned FiltW = $clog2(FILTER_CYCLES + 1);
  localparam int unsigned GapW  = $clog2(STAGE_GAP + 1);
  localparam logic [FiltW-1:0] FiltMax = FiltW'(FILTER_CYCLES);
  localparam logic [GapW-1:0]  GapMax  = GapW'(STAGE_GAP);

  typedef enum logic [1:0] {StIdle, StFilter, StRelease, StRun} state_e;

  state_e               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [FiltW-1:0]     filt_q, filt_d;
  logic [GapW-1:0]      gap_q, gap_d;
  logic [N_DOMAINS-1:0] rst_out_q, rst_out_d;
  logic                 all_rel_q, all_rel_d;
  logic                 lock_s;
  logic [GapW-1:0]      gap_inc;
  logic [N_DOMAINS-1:0] rst_shift;

  assign sync_d    = {sync_q[0], pll_locked};
  assign lock_s    = sync_q[1];
  assign gap_inc   = gap_q + GapW'(1);
  // Asserted bits always form a contiguous upper run, so a left shift frees the lowest one.
  assign rst_shift = rst_out_q << 1;

  always_comb begin
    state_d   = state_q;
    filt_d    = filt_q;
    gap_d     = gap_q;
    rst_out_d = rst_out_q;
    all_rel_d = all_rel_q;
    unique case (state_q)
      StIdle: begin
        rst_out_d = '1;
        all_rel_d = 1'b0;
        filt_d    = '0;
        gap_d     = '0;
        if (lock_s) begin
          state_d = StFilter;
          filt_d  = FiltW'(1);
        end
      end
      StFilter: begin
        if (lock_s) begin
          if (filt_q == FiltMax) begin
            state_d = StRelease;
            gap_d   = '0;
          end else begin
            filt_d = filt_q + FiltW'(1);
          end
        end
      end
      StRelease: begin
        if (lock_s) begin
          if (gap_inc == GapMax) begin
            gap_d     = '0;
            rst_out_d = rst_shift;
            if (rst_shift == '0) begin
              state_d   = StRun;
              all_rel_d = 1'b1;
            end
          end else begin
            gap_d = gap_inc;
          end
        end
      end
      StRun: begin
        rst_out_d = '0;
        all_rel_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Any loss of lock after IDLE drops straight back to full reset.
    if (state_q != StIdle && !lock_s) begin
      state_d   = StIdle;
      rst_out_d = '1;
      all_rel_d = 1'b0;
      filt_d    = '0;
      gap_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sync_q    <= '0;
      filt_q    <= '0;
      gap_q     <= '0;
      rst_out_q <= '1;
      all_rel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      filt_q    <= filt_d;
      gap_q     <= gap_d;
      rst_out_q <= rst_out_d;
      all_rel_q <= all_rel_d;
    end
  end

  assign rst_out      = rst_out_q;
  assign all_released = all_rel_q;

`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
  logic [W_LOSSCNT-1:0] loss_cnt_q, loss_cnt_d;
  logic                 loss_sticky_q, loss_sticky_d;
  logic                 loss_event;

  // Only a drop out of RUN counts; aborted filter/release attempts are not losses.
  assign loss_event = (state_q == StRun) && !lock_s;

  always_comb begin
    loss_cnt_d    = loss_cnt_q;
    loss_sticky_d = loss_sticky_q;
    if (loss_event) begin
      loss_sticky_d = 1'b1;
      if (loss_clear) begin
        loss_cnt_d = W_LOSSCNT'(1);
      end else if (loss_cnt_q != '1) begin
        loss_cnt_d = loss_cnt_q + W_LOSSCNT'(1);
      end
    end else if (loss_clear) begin
      loss_cnt_d    = '0;
      loss_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loss_cnt_q    <= '0;
      loss_sticky_q <= 1'b0;
    end else begin
      loss_cnt_q    <= loss_cnt_d;
      loss_sticky_q <= loss_sticky_d;
    end
  end

  assign loss_count  = loss_cnt_q;
  assign loss_sticky = loss_sticky_q;
`else
  logic unused_loss_clear;
  assign unused_loss_clear = loss_clear;
  assign loss_count        = '0;
  assign loss_sticky       = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: a default 3-domain sequencer and a minimal 1-domain one share the clock;
// every output change is popped against an expected (edge, value) entry queued with the stimulus.
module tb_pll_reset_sequencer;

`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
  localparam bit LossEn = 1'b1;
`else
  localparam bit LossEn = 1'b0;
`endif

  typedef struct packed {
    int          e;
    logic [12:0] v;
  } exp_t;

  logic       clk = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  bit         done_a = 1'b0;
  bit         done_b = 1'b0;
  exp_t       q_a[$];
  exp_t       q_b[$];

  logic       rst_a, lock_a, clr_a, all_rel_a, ls_a;
  logic [2:0] rst_out_a;
  logic [7:0] lc_a;
  logic       rst_b, lock_b, clr_b, all_rel_b, ls_b;
  logic [0:0] rst_out_b;
  logic [1:0] lc_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pll_reset_sequencer #(
    .N_DOMAINS    (3),
    .FILTER_CYCLES(256),
    .STAGE_GAP    (16),
    .W_LOSSCNT    (8)
  ) u_dut_a (
    .clk         (clk),
    .rst         (rst_a),
    .pll_locked  (lock_a),
    .rst_out     (rst_out_a),
    .all_released(all_rel_a),
    .loss_clear  (clr_a),
    .loss_count  (lc_a),
    .loss_sticky (ls_a)
  );

  pll_reset_sequencer #(
    .N_DOMAINS    (1),
    .FILTER_CYCLES(1),
    .STAGE_GAP    (1),
    .W_LOSSCNT    (2)
  ) u_dut_b (
    .clk         (clk),
    .rst         (rst_b),
    .pll_locked  (lock_b),
    .rst_out     (rst_out_b),
    .all_released(all_rel_b),
    .loss_clear  (clr_b),
    .loss_count  (lc_b),
    .loss_sticky (ls_b)
  );

  // Returns at the falling edge just before posedge e, so inputs driven now are sampled at e.
  task automatic wait_for(input int e);
    while (cyc < e - 1) @(negedge clk);
  endtask

  function automatic logic [12:0] pack_a(logic [2:0] r, logic ar, int lc, logic ls);
    return {r, ar, (LossEn ? 8'(lc) : 8'd0), (LossEn ? ls : 1'b0)};
  endfunction

  function automatic logic [12:0] pack_b(logic r, logic ar, int lc, logic ls);
    return {8'd0, r, ar, (LossEn ? 2'(lc) : 2'd0), (LossEn ? ls : 1'b0)};
  endfunction

  function automatic void push_a(int e, logic [12:0] v);
    q_a.push_back('{e: e, v: v});
  endfunction

  function automatic void push_b(int e, logic [12:0] v);
    q_b.push_back('{e: e, v: v});
  endfunction

  task automatic on_change(input bit is_b, input logic [12:0] cur);
    exp_t  x;
    string nm;
    nm = is_b ? "dom1" : "dom3";
    checks++;
    if ((is_b ? q_b.size() : q_a.size()) == 0) begin
      failures++;
      $display("FAIL %s unexpected output change at edge %0d: actual=%h required=no change",
               nm, cyc, cur);
    end else begin
      x = is_b ? q_b.pop_front() : q_a.pop_front();
      if (cyc != x.e) begin
        failures++;
        $display("FAIL %s change edge: actual=%0d required=%0d (value %h)", nm, cyc, x.e, cur);
      end
      checks++;
      if (cur !== x.v) begin
        failures++;
        $display("FAIL %s value at edge %0d {rst_out,all_rel,loss_count,sticky}: actual=%h required=%h",
                 nm, cyc, cur, x.v);
      end
    end
  endtask

  // Monitor: any change on either DUT's outputs must match the head of its queue.
  initial begin
    logic [12:0] prev_a, prev_b, cur_a, cur_b;
    prev_a = 'x;
    prev_b = 'x;
    forever begin
      @(negedge clk);
      cur_a = {rst_out_a, all_rel_a, lc_a, ls_a};
      cur_b = {8'd0, rst_out_b, all_rel_b, lc_b, ls_b};
      if (cur_a !== prev_a) on_change(1'b0, cur_a);
      if (cur_b !== prev_b) on_change(1'b1, cur_b);
      prev_a = cur_a;
      prev_b = cur_b;
    end
  end

  // Three-domain sequencer: full release, RUN loss, filter glitch, mid-release rst, loss/clear.
  initial begin
    rst_a = 1'b1; lock_a = 1'b0; clr_a = 1'b0;
    push_a(1, pack_a(3'b111, 1'b0, 0, 1'b0));
    wait_for(6);
    rst_a = 1'b0; lock_a = 1'b1;
    push_a(280, pack_a(3'b110, 1'b0, 0, 1'b0));
    push_a(296, pack_a(3'b100, 1'b0, 0, 1'b0));
    push_a(312, pack_a(3'b000, 1'b1, 0, 1'b0));
    wait_for(350);
    lock_a = 1'b0;
    push_a(352, pack_a(3'b111, 1'b0, 1, 1'b1));
    wait_for(355);
    lock_a = 1'b1;
    wait_for(505);
    lock_a = 1'b0;
    wait_for(506);
    lock_a = 1'b1;
    push_a(780, pack_a(3'b110, 1'b0, 1, 1'b1));
    wait_for(786);
    rst_a = 1'b1;
    push_a(786, pack_a(3'b111, 1'b0, 0, 1'b0));
    wait_for(787);
    rst_a = 1'b0;
    push_a(1061, pack_a(3'b110, 1'b0, 0, 1'b0));
    push_a(1077, pack_a(3'b100, 1'b0, 0, 1'b0));
    push_a(1093, pack_a(3'b000, 1'b1, 0, 1'b0));
    wait_for(1110);
    lock_a = 1'b0;
    push_a(1112, pack_a(3'b111, 1'b0, 1, 1'b1));
    wait_for(1115);
    lock_a = 1'b1;
    push_a(1389, pack_a(3'b110, 1'b0, 1, 1'b1));
    push_a(1405, pack_a(3'b100, 1'b0, 1, 1'b1));
    push_a(1421, pack_a(3'b000, 1'b1, 1, 1'b1));
    wait_for(1430);
    lock_a = 1'b0;
    // Clear lands on the same edge as the loss event: count must read 1, not 0 or 2.
    push_a(1432, pack_a(3'b111, 1'b0, 1, 1'b1));
    wait_for(1432);
    clr_a = 1'b1;
    wait_for(1433);
    clr_a = 1'b0;
    wait_for(1435);
    lock_a = 1'b1;
    push_a(1709, pack_a(3'b110, 1'b0, 1, 1'b1));
    push_a(1725, pack_a(3'b100, 1'b0, 1, 1'b1));
    push_a(1741, pack_a(3'b000, 1'b1, 1, 1'b1));
    wait_for(1750);
    clr_a = 1'b1;
    if (LossEn) push_a(1750, pack_a(3'b000, 1'b1, 0, 1'b0));
    wait_for(1751);
    clr_a = 1'b0;
    done_a = 1'b1;
  end

  // One-domain sequencer: minimal latency, then six RUN losses to hit saturation and clear.
  initial begin
    int e;
    int cnt;
    rst_b = 1'b1; lock_b = 1'b0; clr_b = 1'b0;
    push_b(1, pack_b(1'b1, 1'b0, 0, 1'b0));
    wait_for(6);
    rst_b = 1'b0; lock_b = 1'b1;
    push_b(10, pack_b(1'b0, 1'b1, 0, 1'b0));
    for (int k = 0; k < 6; k++) begin
      e   = 20 + 10 * k;
      cnt = (k == 5) ? 1 : ((k + 1 > 3) ? 3 : k + 1);
      wait_for(e);
      lock_b = 1'b0;
      push_b(e + 2, pack_b(1'b1, 1'b0, cnt, 1'b1));
      push_b(e + 7, pack_b(1'b0, 1'b1, cnt, 1'b1));
      if (k == 5) begin
        wait_for(e + 2);
        clr_b = 1'b1;
      end
      wait_for(e + 3);
      clr_b  = 1'b0;
      lock_b = 1'b1;
    end
    done_b = 1'b1;
  end

  initial begin
    wait (done_a && done_b);
    for (int i = 0; i < 200 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
    repeat (5) @(negedge clk);
    while (q_a.size() != 0) begin
      exp_t x;
      x = q_a.pop_front();
      checks++;
      failures++;
      $display("FAIL dom3 missing change: actual=none required=%h at edge %0d", x.v, x.e);
    end
    while (q_b.size() != 0) begin
      exp_t x;
      x = q_b.pop_front();
      checks++;
      failures++;
      $display("FAIL dom1 missing change: actual=none required=%h at edge %0d", x.v, x.e);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #30000;
    $display("FAIL watchdog: actual=timeout at edge %0d required=bench completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
